// File: rtl/core_idecode_pipe.sv
// core_idecode_pipe: RV32I (optional RV32M) instruction-decode pipeline stage.
//
// Decodes one 32-bit instruction per accept into register addresses, a
// sign-extended immediate and control strobes, and flags illegal encodings.
// The decoded bundle is held in a main entry that drives the outputs. With
// SKID=1 a second entry absorbs one extra beat so IN_READY can be registered.
//
// Ports:
//   CLK, NRST               clock, synchronous active-low reset
//   FLUSH                   drop held and incoming instructions
//   IN_VALID/IN_READY       fetch handshake; IN_INSTR, IN_PC carry the beat
//   OUT_VALID/OUT_READY     execute handshake
//   OUT_PC, OUT_OPCODE, OUT_FUNCT3, OUT_FUNCT7, OUT_RS1, OUT_RS2, OUT_RD
//                           registered PC and raw instruction fields
//   OUT_IMM                 sign-extended immediate (0 when none or illegal)
//   C_*                     control strobes, C_WB_CODE writeback selector
//   OUT_ILLEGAL             instruction is not a legal encoding
module core_idecode_pipe #(
  parameter int unsigned XLEN = 32,
  parameter bit          EN_M = 1'b0,
  parameter bit          SKID = 1'b1
) (
  input  logic            CLK,
  input  logic            NRST,
  input  logic            FLUSH,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [31:0]     IN_INSTR,
  input  logic [XLEN-1:0] IN_PC,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] OUT_PC,
  output logic [6:0]      OUT_OPCODE,
  output logic [2:0]      OUT_FUNCT3,
  output logic [6:0]      OUT_FUNCT7,
  output logic [4:0]      OUT_RS1,
  output logic [4:0]      OUT_RS2,
  output logic [4:0]      OUT_RD,
  output logic [XLEN-1:0] OUT_IMM,
  output logic            C_ISIMM,
  output logic            C_ALU,
  output logic            C_BRANCH,
  output logic            C_DOLOAD,
  output logic            C_DOSTORE,
  output logic            C_CMEM,
  output logic            C_REG_AWVALID,
  output logic            C_MULDIV,
  output logic [3:0]      C_WB_CODE,
  output logic            OUT_ILLEGAL
);

  // Writeback selector encodings; WbNone must stay zero so reset clears it.
  localparam logic [3:0] WbNone   = 4'd0;
  localparam logic [3:0] WbAlu    = 4'd1;
  localparam logic [3:0] WbLoad   = 4'd2;
  localparam logic [3:0] WbStore  = 4'd3;
  localparam logic [3:0] WbBranch = 4'd4;
  localparam logic [3:0] WbJal    = 4'd5;
  localparam logic [3:0] WbJalr   = 4'd6;
  localparam logic [3:0] WbLui    = 4'd7;
  localparam logic [3:0] WbAuipc  = 4'd8;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  typedef struct packed {
    logic isimm;
    logic alu;
    logic branch;
    logic doload;
    logic dostore;
    logic cmem;
    logic awvalid;
    logic muldiv;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    ctrl_t           ctrl;
    logic [3:0]      wb_code;
    logic            illegal;
  } bundle_t;

  bundle_t dec;
  logic    legal;

  logic signed [11:0] imm_i;
  logic signed [11:0] imm_s;
  logic signed [12:0] imm_b;
  logic signed [20:0] imm_j;
  logic signed [31:0] imm_u;

  assign imm_i = IN_INSTR[31:20];
  assign imm_s = {IN_INSTR[31:25], IN_INSTR[11:7]};
  assign imm_b = {IN_INSTR[31], IN_INSTR[7], IN_INSTR[30:25], IN_INSTR[11:8], 1'b0};
  assign imm_j = {IN_INSTR[31], IN_INSTR[19:12], IN_INSTR[20], IN_INSTR[30:21], 1'b0};
  assign imm_u = {IN_INSTR[31:12], 12'b0};

  // Combinational decode of the incoming word.
  always_comb begin
    dec        = '0;
    legal      = 1'b0;
    dec.pc     = IN_PC;
    dec.opcode = IN_INSTR[6:0];
    dec.funct3 = IN_INSTR[14:12];
    dec.funct7 = IN_INSTR[31:25];
    dec.rs1    = IN_INSTR[19:15];
    dec.rs2    = IN_INSTR[24:20];
    dec.rd     = IN_INSTR[11:7];
    case (IN_INSTR[6:0])
      OpOp: begin
        dec.ctrl.alu     = 1'b1;
        dec.ctrl.awvalid = 1'b1;
        dec.wb_code      = WbAlu;
        case (dec.funct7)
          7'b0000000: legal = 1'b1;
          7'b0100000: legal = (dec.funct3 == 3'b000) || (dec.funct3 == 3'b101);
          7'b0000001: begin
            legal           = EN_M;
            dec.ctrl.muldiv = 1'b1;
          end
          default:    legal = 1'b0;
        endcase
      end
      OpImm: begin
        dec.ctrl.isimm   = 1'b1;
        dec.ctrl.alu     = 1'b1;
        dec.ctrl.awvalid = 1'b1;
        dec.wb_code      = WbAlu;
        dec.imm          = XLEN'(imm_i);
        if (dec.funct3 == 3'b001) begin
          legal = (dec.funct7 == 7'b0000000);
        end else if (dec.funct3 == 3'b101) begin
          legal = (dec.funct7 == 7'b0000000) || (dec.funct7 == 7'b0100000);
        end else begin
          legal = 1'b1;
        end
      end
      OpLoad: begin
        dec.ctrl.isimm   = 1'b1;
        dec.ctrl.cmem    = 1'b1;
        dec.ctrl.doload  = 1'b1;
        dec.ctrl.awvalid = 1'b1;
        dec.wb_code      = WbLoad;
        dec.imm          = XLEN'(imm_i);
        legal = dec.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      end
      OpStore: begin
        dec.ctrl.isimm   = 1'b1;
        dec.ctrl.cmem    = 1'b1;
        dec.ctrl.dostore = 1'b1;
        dec.wb_code      = WbStore;
        dec.imm          = XLEN'(imm_s);
        legal            = (dec.funct3 <= 3'b010);
      end
      OpBranch: begin
        dec.ctrl.isimm  = 1'b1;
        dec.ctrl.branch = 1'b1;
        dec.wb_code     = WbBranch;
        dec.imm         = XLEN'(imm_b);
        legal           = !(dec.funct3 inside {3'b010, 3'b011});
      end
      OpJal: begin
        dec.ctrl.isimm   = 1'b1;
        dec.ctrl.awvalid = 1'b1;
        dec.wb_code      = WbJal;
        dec.imm          = XLEN'(imm_j);
        legal            = 1'b1;
      end
      OpJalr: begin
        dec.ctrl.isimm   = 1'b1;
        dec.ctrl.awvalid = 1'b1;
        dec.wb_code      = WbJalr;
        dec.imm          = XLEN'(imm_i);
        legal            = (dec.funct3 == 3'b000);
      end
      OpLui, OpAuipc: begin
        dec.ctrl.isimm   = 1'b1;
        dec.ctrl.awvalid = 1'b1;
        dec.wb_code      = (IN_INSTR[6:0] == OpLui) ? WbLui : WbAuipc;
        dec.imm          = XLEN'(imm_u);
        legal            = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    // Illegal words still flow through with raw fields, but are inert downstream.
    if (!legal) begin
      dec.imm     = '0;
      dec.ctrl    = '0;
      dec.wb_code = WbNone;
    end
    dec.illegal = !legal;
  end

  bundle_t main_q, main_d, skid_q, skid_d;
  logic    main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic    accept, drain;

  // With SKID the ready is a pure flop output; otherwise it looks through to OUT_READY.
  assign IN_READY = NRST & (SKID ? !skid_valid_q : (!main_valid_q | OUT_READY));
  assign accept   = IN_VALID & IN_READY;
  assign drain    = main_valid_q & OUT_READY;

  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (FLUSH) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || drain) begin
      if (skid_valid_q) begin
        // Older skid beat moves up first to keep FIFO order.
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = accept;
        if (accept) skid_d = dec;
      end else begin
        main_valid_d = accept;
        if (accept) main_d = dec;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign OUT_VALID     = main_valid_q;
  assign OUT_PC        = main_q.pc;
  assign OUT_OPCODE    = main_q.opcode;
  assign OUT_FUNCT3    = main_q.funct3;
  assign OUT_FUNCT7    = main_q.funct7;
  assign OUT_RS1       = main_q.rs1;
  assign OUT_RS2       = main_q.rs2;
  assign OUT_RD        = main_q.rd;
  assign OUT_IMM       = main_q.imm;
  assign C_ISIMM       = main_q.ctrl.isimm;
  assign C_ALU         = main_q.ctrl.alu;
  assign C_BRANCH      = main_q.ctrl.branch;
  assign C_DOLOAD      = main_q.ctrl.doload;
  assign C_DOSTORE     = main_q.ctrl.dostore;
  assign C_CMEM        = main_q.ctrl.cmem;
  assign C_REG_AWVALID = main_q.ctrl.awvalid;
  assign C_MULDIV      = main_q.ctrl.muldiv;
  assign C_WB_CODE     = main_q.wb_code;
  assign OUT_ILLEGAL   = main_q.illegal;

endmodule

// File: tb/tb_core_idecode_pipe.sv
// Bench for core_idecode_pipe: two instances share the stimulus, dut_a
// (XLEN=64, EN_M=0) and dut_b (XLEN=32, EN_M=1), both with SKID=1.
module tb_core_idecode_pipe;

  localparam logic [7:0] KIs = 8'h80, KAlu = 8'h40, KBr = 8'h20, KLd = 8'h10;
  localparam logic [7:0] KSt = 8'h08, KMem = 8'h04, KAw = 8'h02, KMd = 8'h01;
  localparam logic [3:0] WNone = 4'd0, WAlu = 4'd1, WLoad = 4'd2, WStore = 4'd3;
  localparam logic [3:0] WBranch = 4'd4, WJal = 4'd5, WJalr = 4'd6, WLui = 4'd7, WAuipc = 4'd8;

  logic        CLK = 1'b0;
  logic        NRST, FLUSH, IN_VALID, OUT_READY;
  logic [31:0] IN_INSTR;
  logic [63:0] IN_PC;

  logic        a_in_ready, a_out_valid, a_ill;
  logic [63:0] a_pc, a_imm;
  logic [6:0]  a_op, a_f7;
  logic [2:0]  a_f3;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic        a_isimm, a_alu, a_br, a_ld, a_st, a_mem, a_aw, a_md;
  logic [3:0]  a_wb;
  logic        b_in_ready, b_out_valid, b_ill;
  logic [31:0] b_pc, b_imm;
  logic [6:0]  b_op, b_f7;
  logic [2:0]  b_f3;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic        b_isimm, b_alu, b_br, b_ld, b_st, b_mem, b_aw, b_md;
  logic [3:0]  b_wb;
  logic [7:0]  a_ctrl, b_ctrl;

  assign a_ctrl = {a_isimm, a_alu, a_br, a_ld, a_st, a_mem, a_aw, a_md};
  assign b_ctrl = {b_isimm, b_alu, b_br, b_ld, b_st, b_mem, b_aw, b_md};

  always #5 CLK = ~CLK;

  core_idecode_pipe #(.XLEN(64), .EN_M(1'b0), .SKID(1'b1)) dut_a (
    .CLK(CLK), .NRST(NRST), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(a_in_ready),
    .IN_INSTR(IN_INSTR), .IN_PC(IN_PC), .OUT_VALID(a_out_valid), .OUT_READY(OUT_READY),
    .OUT_PC(a_pc), .OUT_OPCODE(a_op), .OUT_FUNCT3(a_f3), .OUT_FUNCT7(a_f7),
    .OUT_RS1(a_rs1), .OUT_RS2(a_rs2), .OUT_RD(a_rd), .OUT_IMM(a_imm),
    .C_ISIMM(a_isimm), .C_ALU(a_alu), .C_BRANCH(a_br), .C_DOLOAD(a_ld), .C_DOSTORE(a_st),
    .C_CMEM(a_mem), .C_REG_AWVALID(a_aw), .C_MULDIV(a_md), .C_WB_CODE(a_wb),
    .OUT_ILLEGAL(a_ill)
  );

  core_idecode_pipe #(.XLEN(32), .EN_M(1'b1), .SKID(1'b1)) dut_b (
    .CLK(CLK), .NRST(NRST), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(b_in_ready),
    .IN_INSTR(IN_INSTR), .IN_PC(IN_PC[31:0]), .OUT_VALID(b_out_valid), .OUT_READY(OUT_READY),
    .OUT_PC(b_pc), .OUT_OPCODE(b_op), .OUT_FUNCT3(b_f3), .OUT_FUNCT7(b_f7),
    .OUT_RS1(b_rs1), .OUT_RS2(b_rs2), .OUT_RD(b_rd), .OUT_IMM(b_imm),
    .C_ISIMM(b_isimm), .C_ALU(b_alu), .C_BRANCH(b_br), .C_DOLOAD(b_ld), .C_DOSTORE(b_st),
    .C_CMEM(b_mem), .C_REG_AWVALID(b_aw), .C_MULDIV(b_md), .C_WB_CODE(b_wb),
    .OUT_ILLEGAL(b_ill)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] imm;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [7:0]  ctrl;
    logic [3:0]  wb;
    logic        ill;
  } exp_t;

  function automatic longint sx(input longint v, input int bits);
    if (v >= (longint'(1) << (bits - 1))) return v - (longint'(1) << bits);
    return v;
  endfunction

  // Reference decode straight from the instruction-set rules.
  function automatic exp_t model(input logic [31:0] w, input logic [63:0] pc, input bit en_m);
    exp_t       e;
    bit         ok;
    longint     imm;
    logic [7:0] c;
    logic [3:0] wb;
    logic [2:0] f3;
    logic [6:0] f7;
    f3  = w[14:12];
    f7  = w[31:25];
    ok  = 1'b1;
    imm = 0;
    c   = 8'h00;
    wb  = WNone;
    case (w[6:0])
      7'h33: begin
        c = KAlu | KAw; wb = WAlu;
        if (f7 == 7'h00) ok = 1'b1;
        else if (f7 == 7'h20) ok = (f3 == 3'd0) || (f3 == 3'd5);
        else if (f7 == 7'h01) begin ok = en_m; c = c | KMd; end
        else ok = 1'b0;
      end
      7'h13: begin
        c = KIs | KAlu | KAw; wb = WAlu; imm = sx(longint'(w[31:20]), 12);
        if (f3 == 3'd1) ok = (f7 == 7'h00);
        else if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
      end
      7'h03: begin
        c = KIs | KMem | KLd | KAw; wb = WLoad; imm = sx(longint'(w[31:20]), 12);
        ok = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
      end
      7'h23: begin
        c = KIs | KMem | KSt; wb = WStore;
        imm = sx(longint'(w[31:25]) * 32 + longint'(w[11:7]), 12);
        ok = (f3 <= 3'd2);
      end
      7'h63: begin
        c = KIs | KBr; wb = WBranch;
        imm = sx(longint'(w[31]) * 4096 + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32
                 + longint'(w[11:8]) * 2, 13);
        ok = (f3 != 3'd2) && (f3 != 3'd3);
      end
      7'h6f: begin
        c = KIs | KAw; wb = WJal;
        imm = sx(longint'(w[31]) * 1048576 + longint'(w[19:12]) * 4096
                 + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2, 21);
      end
      7'h67: begin
        c = KIs | KAw; wb = WJalr; imm = sx(longint'(w[31:20]), 12); ok = (f3 == 3'd0);
      end
      7'h37: begin c = KIs | KAw; wb = WLui;   imm = sx(longint'(w[31:12]) * 4096, 32); end
      7'h17: begin c = KIs | KAw; wb = WAuipc; imm = sx(longint'(w[31:12]) * 4096, 32); end
      default: ok = 1'b0;
    endcase
    if (!ok) begin c = 8'h00; wb = WNone; imm = 0; end
    e.pc = pc; e.imm = imm; e.op = w[6:0]; e.f3 = f3; e.f7 = f7;
    e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
    e.ctrl = c; e.wb = wb; e.ill = !ok;
    return e;
  endfunction

  function automatic exp_t act_a();
    exp_t x;
    x.pc = a_pc; x.imm = a_imm; x.op = a_op; x.f3 = a_f3; x.f7 = a_f7;
    x.rs1 = a_rs1; x.rs2 = a_rs2; x.rd = a_rd; x.ctrl = a_ctrl; x.wb = a_wb; x.ill = a_ill;
    return x;
  endfunction

  function automatic exp_t act_b();
    exp_t x;
    x.pc = {32'h0, b_pc}; x.imm = {32'h0, b_imm}; x.op = b_op; x.f3 = b_f3; x.f7 = b_f7;
    x.rs1 = b_rs1; x.rs2 = b_rs2; x.rd = b_rd; x.ctrl = b_ctrl; x.wb = b_wb; x.ill = b_ill;
    return x;
  endfunction

  // Scoreboard: FIFO of accepted beats, at most two held.
  typedef struct {
    logic [31:0] w;
    logic [63:0] pc;
  } item_t;
  item_t       q[$];
  logic        s_acc = 1'b0, s_xfer = 1'b0, s_flush = 1'b0, s_nrst = 1'b0;
  logic [31:0] s_w = '0;
  logic [63:0] s_pc = '0;

  always @(negedge CLK) begin
    exp_t ea, eb;
    s_nrst  = NRST;
    s_flush = FLUSH;
    s_acc   = IN_VALID & a_in_ready;
    s_xfer  = a_out_valid & OUT_READY;
    s_w     = IN_INSTR;
    s_pc    = IN_PC;
    check("sb_in_ready_a", a_in_ready, NRST && (q.size() < 2));
    check("sb_in_ready_b", b_in_ready, NRST && (q.size() < 2));
    check("sb_out_valid_a", a_out_valid, q.size() > 0);
    check("sb_out_valid_b", b_out_valid, q.size() > 0);
    if (a_out_valid && q.size() > 0) begin
      ea = model(q[0].w, q[0].pc, 1'b0);
      eb = model(q[0].w, q[0].pc, 1'b1);
      eb.pc[63:32]  = 32'h0;
      eb.imm[63:32] = 32'h0;
      check("sb_bundle_a", act_a(), ea);
      check("sb_bundle_b", act_b(), eb);
    end
  end

  always @(posedge CLK) begin
    if (!s_nrst || s_flush) begin
      q.delete();
    end else begin
      if (s_xfer && q.size() > 0) void'(q.pop_front());
      if (s_acc) q.push_back('{w: s_w, pc: s_pc});
    end
  end

  // Directed decode vectors with hand-derived expectations.
  typedef struct {
    logic [31:0] w;
    logic [7:0]  ca;
    logic [3:0]  wa;
    logic [63:0] ia;
    logic        la;
    logic [7:0]  cb;
    logic [3:0]  wbb;
    logic        lb;
  } vec_t;
  vec_t vt[$];

  task automatic add(input logic [31:0] w, input logic [7:0] c, input logic [3:0] wb,
                     input logic [63:0] imm, input logic ill);
    vt.push_back('{w: w, ca: c, wa: wb, ia: imm, la: ill, cb: c, wbb: wb, lb: ill});
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic [63:0] pc);
    IN_VALID = v;
    IN_INSTR = w;
    IN_PC    = pc;
  endtask

  function automatic logic [31:0] gen();
    logic [31:0] w;
    logic [6:0]  ops[9];
    ops = '{7'h03, 7'h23, 7'h63, 7'h67, 7'h6f, 7'h13, 7'h33, 7'h37, 7'h17};
    w = $urandom;
    if ($urandom % 4 != 0) begin
      w[6:0] = ops[$urandom % 9];
      case ($urandom % 4)
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: ;
      endcase
    end
    return w;
  endfunction

  initial begin
    add(32'hFFF10093, KIs | KAlu | KAw, WAlu, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0); // ADDI x1,x2,-1
    add(32'hFE000EE3, KIs | KBr, WBranch, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);      // BEQ -4
    add(32'h800002B7, KIs | KAw, WLui, 64'hFFFF_FFFF_8000_0000, 1'b0);         // LUI 0x80000
    add(32'h00312423, KIs | KMem | KSt, WStore, 64'd8, 1'b0);                  // SW x3,8(x2)
    add(32'hFF80A203, KIs | KMem | KLd | KAw, WLoad, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
    add(32'h001000EF, KIs | KAw, WJal, 64'h800, 1'b0);                         // JAL +2048
    add(32'h00008067, KIs | KAw, WJalr, 64'h0, 1'b0);
    add(32'h12345197, KIs | KAw, WAuipc, 64'h1234_5000, 1'b0);
    add(32'h002081B3, KAlu | KAw, WAlu, 64'h0, 1'b0);                          // ADD
    add(32'h402081B3, KAlu | KAw, WAlu, 64'h0, 1'b0);                          // SUB
    add(32'h40335293, KIs | KAlu | KAw, WAlu, 64'h403, 1'b0);                  // SRAI
    add(32'h00000000, 8'h00, WNone, 64'h0, 1'b1);
    add(32'h40001033, 8'h00, WNone, 64'h0, 1'b1);
    add(32'h00003003, 8'h00, WNone, 64'h0, 1'b1);
    add(32'h40001013, 8'h00, WNone, 64'h0, 1'b1);
    add(32'h00002063, 8'h00, WNone, 64'h0, 1'b1);
    add(32'h00003023, 8'h00, WNone, 64'h0, 1'b1);
    add(32'h00009067, 8'h00, WNone, 64'h0, 1'b1);
    vt.push_back('{w: 32'h02000033, ca: 8'h00, wa: WNone, ia: 64'h0, la: 1'b1,
                   cb: KAlu | KAw | KMd, wbb: WAlu, lb: 1'b0});                // MUL

    NRST = 1'b0; FLUSH = 1'b0; OUT_READY = 1'b0;
    drive(1'b0, 32'h0, 64'h0);
    step();
    step();
    check("rst_out_valid", a_out_valid, 1'b0);
    check("rst_pc", a_pc, 64'h0);
    check("rst_imm", a_imm, 64'h0);
    check("rst_ctrl", a_ctrl, 8'h00);
    check("rst_wb", a_wb, WNone);
    check("rst_in_ready_low", a_in_ready, 1'b0);
    NRST = 1'b1;
    #1;
    check("rst_in_ready_release", a_in_ready, 1'b1);

    // Back-to-back stream through the table, one beat per cycle.
    OUT_READY = 1'b1;
    foreach (vt[i]) begin
      drive(1'b1, vt[i].w, 64'h1000 + 64'(4 * i));
      step();
      check("vec_valid", a_out_valid, 1'b1);
      check("vec_pc", a_pc, 64'h1000 + 64'(4 * i));
      check("vec_fields", {a_op, a_rd, a_rs1, a_rs2},
            {vt[i].w[6:0], vt[i].w[11:7], vt[i].w[19:15], vt[i].w[24:20]});
      check("vec_a_ctrl", a_ctrl, vt[i].ca);
      check("vec_a_wb", a_wb, vt[i].wa);
      check("vec_a_imm", a_imm, vt[i].ia);
      check("vec_a_ill", a_ill, vt[i].la);
      check("vec_b_ctrl", b_ctrl, vt[i].cb);
      check("vec_b_wb", b_wb, vt[i].wbb);
      check("vec_b_imm", b_imm, vt[i].ia[31:0]);
      check("vec_b_ill", b_ill, vt[i].lb);
    end
    drive(1'b0, 32'h0, 64'h0);
    step();
    check("vec_drained", a_out_valid, 1'b0);

    // Skid fill: two captured, third held, then drained without a gap.
    OUT_READY = 1'b0;
    drive(1'b1, 32'h002081B3, 64'h100);
    step();
    drive(1'b1, 32'h00312423, 64'h104);
    step();
    check("skid_ready_low", a_in_ready, 1'b0);
    check("skid_head_pc", a_pc, 64'h100);
    drive(1'b1, 32'hFFF10093, 64'h108);
    step();
    check("skid_hold_ready", a_in_ready, 1'b0);
    check("skid_hold_pc", a_pc, 64'h100);
    OUT_READY = 1'b1;
    step();
    check("skid_beat2_pc", a_pc, 64'h104);
    check("skid_ready_back", a_in_ready, 1'b1);
    step();
    check("skid_beat3_valid", a_out_valid, 1'b1);
    check("skid_beat3_pc", a_pc, 64'h108);
    drive(1'b0, 32'h0, 64'h0);
    step();
    check("skid_empty", a_out_valid, 1'b0);

    // Flush of a full, stalled buffer with an instruction presented.
    OUT_READY = 1'b0;
    drive(1'b1, 32'h002081B3, 64'h200);
    step();
    drive(1'b1, 32'h402081B3, 64'h204);
    step();
    drive(1'b1, 32'h00008067, 64'h208);
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    drive(1'b0, 32'h0, 64'h0);
    check("flush_valid", a_out_valid, 1'b0);
    check("flush_ready", a_in_ready, 1'b1);
    // Flush while accepting into an empty stage: the beat is dropped too.
    drive(1'b1, 32'h12345197, 64'h20C);
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    drive(1'b0, 32'h0, 64'h0);
    OUT_READY = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("flush_no_beat", a_out_valid, 1'b0);
    end

    // Reset in the middle of a stall.
    OUT_READY = 1'b0;
    drive(1'b1, 32'h001000EF, 64'h300);
    step();
    drive(1'b1, 32'hFE000EE3, 64'h304);
    step();
    NRST = 1'b0;
    #1;
    check("mid_rst_ready", a_in_ready, 1'b0);
    step();
    check("mid_rst_valid", a_out_valid, 1'b0);
    check("mid_rst_pc", a_pc, 64'h0);
    check("mid_rst_wb", a_wb, WNone);
    NRST = 1'b1;
    OUT_READY = 1'b1;
    drive(1'b1, 32'hFFF10093, 64'h400);
    step();
    check("mid_rst_resume_valid", a_out_valid, 1'b1);
    check("mid_rst_resume_pc", a_pc, 64'h400);
    drive(1'b0, 32'h0, 64'h0);
    step();

    // Randomised traffic against the scoreboard.
    for (int k = 0; k < 3000; k++) begin
      drive(($urandom % 4) != 0, gen(), {$urandom, $urandom});
      OUT_READY = ($urandom % 3) != 0;
      FLUSH     = ($urandom % 40) == 0;
      NRST      = ($urandom % 150) != 0;
      step();
    end
    NRST = 1'b1; FLUSH = 1'b0; OUT_READY = 1'b1;
    drive(1'b0, 32'h0, 64'h0);
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
